// File: rtl/led_flow_ctrl.sv
// Multi-channel LED pattern driver: blink-all, flow left/right and bounce, stepped every
// STEP_CYCLES clocks with a per-step on-time gate and a registered step pulse.
module led_flow_ctrl #(
    parameter int unsigned N_LED       = 4,
    parameter int unsigned STEP_CYCLES = 5_000_000,
    parameter int unsigned CNT_W       = 23
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic [N_LED-1:0] led_out_o,
    output logic             step_tick_o
);

    localparam int unsigned      PosW    = $clog2(N_LED);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STEP_CYCLES - 1);
    localparam logic [PosW-1:0]  PosLast = PosW'(N_LED - 1);

    typedef enum logic [1:0] {
        ModeBlink  = 2'b00,
        ModeLeft   = 2'b01,
        ModeRight  = 2'b10,
        ModeBounce = 2'b11
    } mode_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PosW-1:0]  pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             ph_q, ph_d;
    mode_e            mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             tick_q, tick_d;

    logic             boundary;
    logic             led_on;
    logic [N_LED-1:0] pattern;
    logic [PosW-1:0]  pos_inc, pos_dec;
    mode_e            mode_in;

    always_comb begin
        boundary = (cnt_q == CntLast);
        led_on   = (cnt_q < duty_i);
        mode_in  = mode_e'(mode_i);
        pos_inc  = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
        pos_dec  = (pos_q == '0) ? PosLast : pos_q - 1'b1;

        if (mode_q == ModeBlink) begin
            pattern = {N_LED{ph_q}};
        end else begin
            pattern = N_LED'(1) << pos_q;
        end

        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        mode_d = mode_q;
        led_d  = led_q;
        tick_d = 1'b0;

        if (en_i) begin
            cnt_d  = boundary ? '0 : cnt_q + 1'b1;
            led_d  = pattern & {N_LED{led_on}};
            tick_d = boundary;
            if (boundary) begin
                mode_d = mode_in;
                if (mode_in != mode_q) begin
                    unique case (mode_in)
                        ModeBlink:  ph_d = 1'b1;
                        ModeLeft:   pos_d = '0;
                        ModeRight:  pos_d = PosLast;
                        ModeBounce: begin
                            pos_d = '0;
                            dir_d = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    unique case (mode_q)
                        ModeBlink:  ph_d = ~ph_q;
                        ModeLeft:   pos_d = pos_inc;
                        ModeRight:  pos_d = pos_dec;
                        ModeBounce: begin
                            // Direction flips as soon as an end is reached, so ends show once.
                            if (!dir_q) begin
                                pos_d = pos_inc;
                                dir_d = (pos_inc == PosLast);
                            end else begin
                                pos_d = pos_dec;
                                dir_d = (pos_dec != '0);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            ph_q   <= 1'b0;
            mode_q <= ModeBlink;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led_out_o   = led_q;
    assign step_tick_o = tick_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Randomised bench for led_flow_ctrl against a step-indexed behavioural pattern model.
module tb_led_flow_ctrl;

    localparam int N  = 4;
    localparam int SC = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] duty = '0;
    logic [N-1:0]  led;
    logic          tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycle within step, latched mode, and steps since the last restart.
    int         m_cnt = 0;
    int         m_mode = 0;
    int         m_step = 1;
    logic [N-1:0] m_led = '0;
    logic       m_tick = 1'b0;

    led_flow_ctrl #(
        .N_LED      (N),
        .STEP_CYCLES(SC),
        .CNT_W      (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .duty_i     (duty),
        .led_out_o  (led),
        .step_tick_o(tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_pattern(input int md, input int s);
        int p;
        int per;
        case (md)
            0: return (s % 2 == 0) ? {N{1'b1}} : '0;
            1: p = s % N;
            2: p = N - 1 - (s % N);
            default: begin
                per = 2 * N - 2;
                p = s % per;
                if (p >= N) p = per - p;
            end
        endcase
        return N'(1 << p);
    endfunction

    task automatic model_step(input logic r, input logic e, input int md, input int d);
        if (!r) begin
            m_cnt  = 0;
            m_mode = 0;
            m_step = 1;  // blink phase 0 right after reset
            m_led  = '0;
            m_tick = 1'b0;
        end else if (e) begin
            m_led  = (m_cnt < d) ? model_pattern(m_mode, m_step) : '0;
            m_tick = (m_cnt == SC - 1);
            if (m_cnt == SC - 1) begin
                m_cnt = 0;
                if (md != m_mode) begin
                    m_mode = md;
                    m_step = 0;
                end else begin
                    m_step++;
                end
            end else begin
                m_cnt++;
            end
        end else begin
            m_tick = 1'b0;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [1:0] md, input logic [CW-1:0] d);
        rst_n = r;
        en    = e;
        mode  = md;
        duty  = d;
        @(posedge clk);
        model_step(r, e, int'(md), int'(d));
        #1;
        check_eq("led_out", 32'(led), 32'(m_led));
        check_eq("step_tick", 32'(tick), 32'(m_tick));
    endtask

    initial begin
        logic          r_e;
        logic          r_r;
        logic [1:0]    r_m;
        logic [CW-1:0] r_d;

        // Reset with flow-left selected, then run it through several steps.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b01, 4'd10);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 2'b01, 4'd10);
        // Bounce with full duty, then dark run with zero duty.
        for (int i = 0; i < 90; i++) cycle(1'b1, 1'b1, 2'b11, 4'd15);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 2'b11, 4'd0);
        // Flow right with partial duty.
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 2'b10, 4'd3);

        r_m = 2'b00;
        r_d = 4'd7;
        for (int i = 0; i < 3000; i++) begin
            r_e = ($urandom_range(0, 7) != 0);
            r_r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 24) == 0) r_m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) r_d = CW'($urandom_range(0, 15));
            cycle(r_r, r_e, r_m, r_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
